ack_frame_encoder: RTL and testbench
====================================

# ack_frame_encoder

Generates the ASCII command frame "ACK <n>\n" for an arbitrary 16-bit value and streams it byte by byte into a `uart_tx` instance, which drives the super counter's `uart_rx` line in the simulation wrapper. It replaces the fixed-message ACK generator with a runtime-programmable one. Binary-to-decimal conversion is a sequential double-dabble with leading-zero suppression, and the transmitter is driven with a start/busy handshake.

## Interface
- `VALUE_W`, default 16: width of `value`. Fixed at 16; 5 BCD digits.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `value`  in  16: number to encode; sampled only on an accepted `send`.
- `send`  in  1: request a frame; level-sampled, honoured only in IDLE.
- `tx_busy`  in  1: `uart_tx` busy. High from the cycle after `tx_start` until the stop bit ends.
- `tx_data`  out  8: byte presented to `uart_tx`; registered.
- `tx_start`  out  1: one-cycle start strobe to `uart_tx`; registered.
- `busy`  out  1: frame in progress (CONVERT through last byte).
- `done`  out  1: one-cycle pulse when the final byte has left the transmitter.

## Operation
- Reset values: `tx_data`=0, `tx_start`=0, `busy`=0, `done`=0, state=IDLE, all BCD/index registers=0.
- States: IDLE, CONVERT, SEND, WAIT_ACC, WAIT_DONE.
- **IDLE**
  - On `send`=1: latch `value`, clear BCD, set `busy`, go to CONVERT.
  - `send` is ignored in every other state. There is no queueing.
- **CONVERT**
  - Double-dabble runs exactly 16 iterations. Each iteration: add 3 to every BCD nibble that is 5 or more, then shift left one bit, pulling in the value MSB.
  - Then compute `first_digit` = index of the most significant non-zero nibble, or 0 if value==0.
  - Then go to SEND.
- **Frame byte order**
  - 'A' 0x41, 'C' 0x43, 'K' 0x4B, ' ' 0x20.
  - Digits from `first_digit` down to nibble 0, each as 0x30+nibble.
  - 0x0A.
  - Frame length = 5 + number of significant digits: 6 bytes minimum (value 0), 10 bytes maximum (65535).
- **SEND**
  - If `tx_busy`=0: load `tx_data` with the current byte, pulse `tx_start` for one cycle, go to WAIT_ACC.
  - Otherwise hold in SEND.
- **WAIT_ACC**: wait for `tx_busy`=1, then go to WAIT_DONE. This prevents double-issue in the cycle right after `tx_start`.
- **WAIT_DONE**: wait for `tx_busy`=0.
  - If the byte just sent was the last: go to IDLE, drop `busy`, pulse `done`.
  - Otherwise advance the byte index and go to SEND.
- `tx_data` holds its last value between bytes. Only `tx_start` qualifies it.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. The partially transmitted byte is abandoned; `uart_tx` is reset by the same `rst`.

## Timing
- `send` sampled high at edge E: `busy`=1 after E, CONVERT occupies edges E+1…E+16, SEND entered after E+17.
- With `tx_busy` low, the first `tx_start`=1 is the cycle after edge E+18.
- `tx_start` is never high on two consecutive cycles. At most one `tx_start` per `tx_busy` high period.
- Per byte overhead: 2 cycles beyond the transmitter's busy time (SEND plus WAIT_DONE exit).
- `done` and `busy` falling occur on the same edge, which is the edge after `tx_busy` falls for the last byte.
- `send` held high continuously: a new frame starts on the cycle after `done`, latching the then-current `value`.
- `send` in the same cycle as `rst`: reset wins.

## Configuration
- `ACK_ENC_CRLF_EN` defined: the terminator is 0x0D 0x0A, so the frame is one byte longer (7–11 bytes).
- `ACK_ENC_CRLF_EN` undefined: the terminator is the single byte 0x0A.
- The state machine is unchanged either way; only the last-byte index moves.

## Test plan
- **Value 100.** `send` one cycle with `value`=100 and a `uart_tx` model, macro undefined.
  - Required: the decoded bytes are 41 43 4B 20 31 30 30 0A, there are exactly 8 `tx_start` pulses, `done` pulses once, and `busy` is low afterwards.
- **Boundary values.** `value`=0, then `value`=65535.
  - Required: "ACK 0\n" (6 bytes), then "ACK 65535\n" (10 bytes).
  - Required: `value`=1000 gives "ACK 1000\n", with the inner zeros kept.
- **Latency and busy hold-off.** `tx_busy` is forced low and the edge of the first `tx_start` is measured.
  - Required: the edge is E+18.
  - Then `tx_busy` is held high 50 cycles after SEND is entered. Required: `tx_start` stays 0 until `tx_busy` drops.
- **Busy-time stimulus.** `send` is re-pulsed and `value` is changed during a frame.
  - Required: the ongoing frame is unaffected, no extra frame is produced, and the latched value is used.
- **Reset mid-operation.** `rst` is asserted during CONVERT and again during byte 3.
  - Required: all outputs return to 0 on the next cycle.
  - Required: a subsequent `send` with `value`=42 yields a clean "ACK 42\n".
- **CRLF build.** `ACK_ENC_CRLF_EN` is defined and `value`=7 is sent.
  - Required: the bytes are 41 43 4B 20 37 0D 0A and `done` pulses after 7 bytes.

Source files
------------

// File: rtl/ack_frame_encoder.sv
// ack_frame_encoder
// Builds the ASCII command frame "ACK <n>\n" for a 16-bit value and streams it
// one byte at a time into a uart_tx instance using a start/busy handshake.
// The binary value is converted to BCD with a sequential double-dabble (one
// iteration per clock), and leading zero digits are suppressed.
//
// Build option: define ACK_ENC_CRLF_EN to terminate the frame with 0x0D 0x0A
// instead of the single byte 0x0A. Only the index of the last byte changes;
// the state machine is identical in both builds.

module ack_frame_encoder #(
  parameter int VALUE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               send,
  input  logic               tx_busy,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic               done
);

  // Five BCD digits cover the full 16-bit range (0..65535).
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Edge count spent in CONVERT: 16 shift iterations plus one edge to locate
  // the leading digit.
  localparam logic [4:0] ITER_LAST = 5'd16;

  // Number of terminator bytes after the last digit.
`ifdef ACK_ENC_CRLF_EN
  localparam logic [3:0] TERM_LEN = 4'd2;
`else
  localparam logic [3:0] TERM_LEN = 4'd1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONVERT   = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACC  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Double-dabble correction: add 3 to every nibble that is 5 or more so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [3:0]       nib;
    res = {BCD_W{1'b0}};
    for (int i = 0; i < BCD_DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) begin
        res[4*i +: 4] = nib + 4'd3;
      end else begin
        res[4*i +: 4] = nib;
      end
    end
    return res;
  endfunction

  // Index of the most significant non-zero digit; 0 when every digit is zero,
  // so the value 0 still produces a single '0' character.
  function automatic logic [2:0] msd_index(input logic [BCD_W-1:0] bcd);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Select one BCD digit by index.
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd,
                                          input logic [2:0]       sel);
    logic [3:0] d;
    case (sel)
      3'd0:    d = bcd[3:0];
      3'd1:    d = bcd[7:4];
      3'd2:    d = bcd[11:8];
      3'd3:    d = bcd[15:12];
      3'd4:    d = bcd[19:16];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // Frame byte at position idx: "ACK ", then digits from the leading one down
  // to digit 0, then the terminator.
  function automatic logic [7:0] frame_byte(input logic [3:0]       idx,
                                            input logic [2:0]       first_digit,
                                            input logic [BCD_W-1:0] bcd);
    logic [3:0] pos;
    logic [7:0] b;
    pos = idx - 4'd4;
    case (idx)
      4'd0:    b = 8'h41;
      4'd1:    b = 8'h43;
      4'd2:    b = 8'h4B;
      4'd3:    b = 8'h20;
      default: begin
        if (pos <= {1'b0, first_digit}) begin
          b = 8'h30 + {4'h0, digit_at(bcd, first_digit - pos[2:0])};
`ifdef ACK_ENC_CRLF_EN
        end else if (pos == ({1'b0, first_digit} + 4'd1)) begin
          b = 8'h0D;
`endif
        end else begin
          b = 8'h0A;
        end
      end
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_r,       state_s;
  logic [VALUE_W-1:0] value_r,       value_s;
  logic [BCD_W-1:0]   bcd_r,         bcd_s;
  logic [4:0]         iter_r,        iter_s;
  logic [2:0]         first_digit_r, first_digit_s;
  logic [3:0]         byte_idx_r,    byte_idx_s;
  logic [7:0]         tx_data_r,     tx_data_s;
  logic               tx_start_r,    tx_start_s;
  logic               busy_r,        busy_s;
  logic               done_r,        done_s;

  logic [BCD_W-1:0]   bcd_adj_s;
  logic [7:0]         cur_byte_s;
  logic [3:0]         last_idx_s;

  // Datapath helpers: corrected BCD for the next shift, current frame byte,
  // and the index of the final byte of this frame.
  always_comb begin
    bcd_adj_s  = add3_digits(bcd_r);
    cur_byte_s = frame_byte(byte_idx_r, first_digit_r, bcd_r);
    last_idx_s = 4'd4 + {1'b0, first_digit_r} + TERM_LEN;
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s       = state_r;
    value_s       = value_r;
    bcd_s         = bcd_r;
    iter_s        = iter_r;
    first_digit_s = first_digit_r;
    byte_idx_s    = byte_idx_r;
    tx_data_s     = tx_data_r;
    tx_start_s    = 1'b0;
    busy_s        = busy_r;
    done_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (send) begin
          value_s    = value;
          bcd_s      = {BCD_W{1'b0}};
          iter_s     = 5'd0;
          byte_idx_s = 4'd0;
          busy_s     = 1'b1;
          state_s    = ST_CONVERT;
        end else begin
          state_s    = ST_IDLE;
        end
      end

      ST_CONVERT: begin
        if (iter_r == ITER_LAST) begin
          first_digit_s = msd_index(bcd_r);
          byte_idx_s    = 4'd0;
          state_s       = ST_SEND;
        end else begin
          bcd_s   = {bcd_adj_s[BCD_W-2:0], value_r[VALUE_W-1]};
          value_s = {value_r[VALUE_W-2:0], 1'b0};
          iter_s  = iter_r + 5'd1;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_s  = cur_byte_s;
          tx_start_s = 1'b1;
          state_s    = ST_WAIT_ACC;
        end else begin
          state_s    = ST_SEND;
        end
      end

      // The transmitter raises busy one cycle after the strobe; waiting for it
      // here keeps SEND from issuing the same byte twice.
      ST_WAIT_ACC: begin
        if (tx_busy) begin
          state_s = ST_WAIT_DONE;
        end else begin
          state_s = ST_WAIT_ACC;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx_r == last_idx_s) begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            byte_idx_s = byte_idx_r + 4'd1;
            state_s    = ST_SEND;
          end
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end

      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      value_r       <= {VALUE_W{1'b0}};
      bcd_r         <= {BCD_W{1'b0}};
      iter_r        <= 5'd0;
      first_digit_r <= 3'd0;
      byte_idx_r    <= 4'd0;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      value_r       <= value_s;
      bcd_r         <= bcd_s;
      iter_r        <= iter_s;
      first_digit_r <= first_digit_s;
      byte_idx_r    <= byte_idx_s;
      tx_data_r     <= tx_data_s;
      tx_start_r    <= tx_start_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_start = tx_start_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_ack_frame_encoder.sv
// Testbench for ack_frame_encoder: a small uart_tx busy model, a reference
// model that formats "ACK <n>" as text, and a scoreboard monitor that checks
// every strobed byte and every done pulse against the expected queue.

module tb_ack_frame_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        send;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        done;

  logic        model_busy = 1'b0;
  logic        force_busy = 1'b0;
  int unsigned model_cnt  = 0;

  int   exp_q[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   start_cnt = 0;
  int   done_cnt  = 0;
  logic prev_start = 1'b0;
  int   mon_e;

  localparam int END_MARK = 256;

  always #5 clk = ~clk;

  assign tx_busy = model_busy | force_busy;

  ack_frame_encoder #(.VALUE_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .send     (send),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: the frame is simply the decimal text of the value.
  task automatic push_frame(input int v);
    string s;
    s = $sformatf("ACK %0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(int'(s[i]));
`ifdef ACK_ENC_CRLF_EN
    exp_q.push_back(13);
`endif
    exp_q.push_back(10);
    exp_q.push_back(END_MARK);
  endtask

  // uart_tx model: busy from the cycle after the strobe for a random time.
  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_busy) begin
      if (model_cnt == 0) model_busy <= 1'b0;
      else                model_cnt  <= model_cnt - 1;
    end else if (tx_start) begin
      model_busy <= 1'b1;
      model_cnt  <= $urandom_range(1, 5);
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        start_cnt <= start_cnt + 1;
        check("start_spacing", int'(prev_start), 0);
        check("busy_with_start", int'(busy), 1);
        check("byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("tx_data", int'(tx_data), mon_e);
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        mon_e = -1;
        if (exp_q.size() > 0) mon_e = exp_q.pop_front();
        check("frame_end_at_done", mon_e, END_MARK);
        check("busy_at_done", int'(busy), 0);
      end
    end
    prev_start <= tx_start;
  end

  task automatic start_frame(input int v);
    @(posedge clk); #1;
    value = v[15:0];
    send  = 1'b1;
    push_frame(v);
    @(posedge clk); #1;
    send  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) break;
    end
    check("frame_complete_in_time", int'(k < 3000), 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int viol;
    int base;
    int v;

    rst   = 1'b1;
    send  = 1'b0;
    value = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("init_tx_data", int'(tx_data), 0);
    check("init_tx_start", int'(tx_start), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    rst = 1'b0;

    // Directed values, including boundaries and inner zeros.
    start_frame(100);   wait_idle();
    start_frame(0);     wait_idle();
    start_frame(65535); wait_idle();
    start_frame(1000);  wait_idle();
    start_frame(7);     wait_idle();

    // Latency from the accepting edge to the first strobe.
    start_frame(123);
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++; #1;
      if (tx_start) break;
    end
    check("first_start_edge", n, 18);
    wait_idle();

    // Transmitter busy hold-off: no strobe while tx_busy is held high.
    start_frame(4321);
    force_busy = 1'b1;
    viol = 0;
    repeat (67) begin
      @(posedge clk); #1;
      if (tx_start) viol++;
    end
    check("holdoff_starts", viol, 0);
    force_busy = 1'b0;
    wait_idle();

    // send and value toggled mid-frame must not disturb the frame.
    base = done_cnt;
    start_frame(31415);
    repeat (30) @(posedge clk);
    #1;
    value = 16'($urandom_range(0, 65535));
    send  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send = 1'b0;
    wait_idle();
    repeat (30) @(posedge clk);
    #1;
    check("frames_after_busy_send", done_cnt - base, 1);

    // send held high: the next frame starts right after done with the new value.
    @(posedge clk); #1;
    value = 16'd808;
    send  = 1'b1;
    push_frame(808);
    push_frame(9);
    @(posedge clk); #1;
    value = 16'd9;
    n = 0;
    while (n < 3000 && !done) begin
      @(posedge clk); n++; #1;
    end
    check("held_send_first_done", int'(n < 3000), 1);
    @(posedge clk); #1;
    send = 1'b0;
    wait_idle();

    // Reset during CONVERT abandons the frame.
    base = start_cnt;
    start_frame(555);
    repeat (4) @(posedge clk);
    reset_pulse();
    repeat (40) @(posedge clk);
    #1;
    check("no_start_after_convert_rst", start_cnt - base, 0);

    // Reset during the fourth byte, then a clean frame.
    base = start_cnt;
    start_frame(60001);
    n = 0;
    while (n < 3000 && start_cnt < base + 4) begin
      @(posedge clk); n++; #1;
    end
    check("reached_byte3", int'(n < 3000), 1);
    reset_pulse();
    start_frame(42);
    wait_idle();

    // send in the same cycle as rst: reset wins.
    base = start_cnt;
    @(posedge clk); #1;
    rst   = 1'b1;
    send  = 1'b1;
    value = 16'd5;
    @(posedge clk); #1;
    rst  = 1'b0;
    send = 1'b0;
    check("send_with_rst_busy", int'(busy), 0);
    repeat (30) @(posedge clk);
    #1;
    check("send_with_rst_no_frame", start_cnt - base, 0);

    // Randomised values of varying magnitude.
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      start_frame(v);
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
